// File: rtl/stream_arbiter_rr_pkg.sv
// Shared constants and helpers for the stream_arbiter_rr slice.
// Optional build macro: STREAM_ARB_PKT_LOCK_EN (used by the top-level arbiter).
package stream_arbiter_rr_pkg;

  localparam int unsigned MAX_N = 16;

  // FSM encodings, kept as plain constants for legacy compatibility
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // Ceiling log2; clog2(1) = 0
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Index width, never below one bit so single-channel builds still have a port
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_arbiter_rr_if.sv
// Bundle of the arbiter's channel, sink and exception signals.
// master: the arbiter side; slave: the surrounding processes and sink.
interface stream_arbiter_rr_if
  import stream_arbiter_rr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 32
);

  localparam int unsigned IDXW = idx_width(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_stb;
  logic [N-1:0]       in_ack;
  logic [WIDTH-1:0]   out_data;
  logic               out_stb;
  logic               out_ack;
  logic [N-1:0]       exc_in;
  logic               exc_clear;
  logic               exception;
  logic [IDXW-1:0]    exc_src;

  modport master (
    input  in_data, in_stb, out_ack, exc_in, exc_clear,
    output in_ack, out_data, out_stb, exception, exc_src
  );

  modport slave (
    output in_data, in_stb, out_ack, exc_in, exc_clear,
    input  in_ack, out_data, out_stb, exception, exc_src
  );

endinterface

// File: rtl/stream_arbiter_rr_rr_select.sv
// Combinational rotating priority pick: first set request at or after ptr,
// wrapping from N-1 back to 0. With ptr tied to zero it is a lowest-index pick.
module rr_select #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [IDXW-1:0] grant,
  output logic            valid
);

  int unsigned pos;

  // Scan from farthest to nearest so the closest request to ptr is written last
  always_comb begin
    grant = '0;
    valid = |req;
    pos   = 0;
    for (int unsigned i = N; i > 0; i--) begin
      pos = (32'(ptr) + i - 1) % N;
      if (req[pos]) grant = IDXW'(pos);
    end
  end

endmodule

// File: rtl/stream_arbiter_rr.sv
// N-channel round-robin merger of stb/ack word streams onto one output,
// plus a sticky exception flag that records the first faulting channel.
// Build macro STREAM_ARB_PKT_LOCK_EN: bit WIDTH-1 marks end-of-packet and a
// granted channel keeps the output until its packet completes.
module stream_arbiter_rr
  import stream_arbiter_rr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  stream_arbiter_rr_if.master bus
);

  localparam int unsigned   IDXW     = idx_width(N);
  localparam logic [IDXW-1:0] PTR_ZERO = '0;

  logic [0:0]      state;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] grant_q;
  logic [N-1:0]    in_ack_q;
  logic [WIDTH-1:0] out_data_q;
  logic            out_stb_q;
  logic            exception_q;
  logic [IDXW-1:0] exc_src_q;

  logic [N-1:0]    req;
  logic [IDXW-1:0] sel;
  logic            sel_valid;
  logic [WIDTH-1:0] sel_word;
  logic [N-1:0]    sel_onehot;
  logic [IDXW-1:0] ptr_next;
  logic [IDXW-1:0] exc_idx;
  logic            exc_any;

`ifdef STREAM_ARB_PKT_LOCK_EN
  logic lock_q;

  // While a packet is open only its owner (still held in grant_q) may be granted
  always_comb begin
    req = '0;
    for (int unsigned k = 0; k < N; k++) begin
      req[k] = bus.in_stb[k] & (~lock_q | (grant_q == IDXW'(k)));
    end
  end
`else
  // Plain per-word arbitration over all requesting channels
  always_comb begin
    req = bus.in_stb;
  end
`endif

  rr_select #(.N(N), .IDXW(IDXW)) u_grant_sel (
    .req   (req),
    .ptr   (ptr),
    .grant (sel),
    .valid (sel_valid)
  );

  rr_select #(.N(N), .IDXW(IDXW)) u_exc_sel (
    .req   (bus.exc_in),
    .ptr   (PTR_ZERO),
    .grant (exc_idx),
    .valid (exc_any)
  );

  // Word mux, accept one-hot, and the pointer position just past the last grant
  always_comb begin
    sel_word   = '0;
    sel_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel == IDXW'(k)) begin
        sel_word      = bus.in_data[k*WIDTH +: WIDTH];
        sel_onehot[k] = 1'b1;
      end
    end
    ptr_next = (grant_q == IDXW'(N - 1)) ? '0 : grant_q + 1'b1;
  end

  // Grant / hold-until-accepted state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_q    <= '0;
      in_ack_q   <= '0;
      out_data_q <= '0;
      out_stb_q  <= 1'b0;
`ifdef STREAM_ARB_PKT_LOCK_EN
      lock_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            in_ack_q   <= sel_onehot;
            out_data_q <= sel_word;
            out_stb_q  <= 1'b1;
            grant_q    <= sel;
            state      <= SEND;
          end else begin
            in_ack_q <= '0;
          end
        end
        SEND: begin
          in_ack_q <= '0;
          if (bus.out_ack) begin
            out_stb_q <= 1'b0;
            state     <= IDLE;
`ifdef STREAM_ARB_PKT_LOCK_EN
            // Pointer only moves once the owner's end-of-packet word is accepted
            if (out_data_q[WIDTH-1]) begin
              lock_q <= 1'b0;
              ptr    <= ptr_next;
            end else begin
              lock_q <= 1'b1;
            end
`else
            ptr <= ptr_next;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky exception; a fresh exception takes priority over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      exception_q <= 1'b0;
      exc_src_q   <= '0;
    end else if (exc_any && (bus.exc_clear || !exception_q)) begin
      exception_q <= 1'b1;
      exc_src_q   <= exc_idx;
    end else if (bus.exc_clear) begin
      exception_q <= 1'b0;
      exc_src_q   <= '0;
    end
  end

  assign bus.in_ack    = in_ack_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_stb   = out_stb_q;
  assign bus.exception = exception_q;
  assign bus.exc_src   = exc_src_q;

endmodule

// File: tb/tb_stream_arbiter_rr.sv
// Self-checking bench for stream_arbiter_rr (N=4, WIDTH=32): directed steps
// followed by a randomized phase, all against a cycle-level reference model.
module tb_stream_arbiter_rr;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

`ifdef STREAM_ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
  int exp6 [5] = '{0, 0, 0, 1, 1};
`else
  localparam bit LOCK_EN = 1'b0;
  int exp6 [5] = '{0, 1, 0, 1, 0};
`endif
  int exp2 [5] = '{0, 1, 2, 3, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  stream_arbiter_rr_if #(.N(N), .WIDTH(W)) bus ();

  stream_arbiter_rr #(.N(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_busy, m_stb, m_exc, m_lock;
  int         m_g, m_ptr, m_src;
  logic [N-1:0] m_ack;
  logic [W-1:0] m_data;

  // Observed grant order
  int dut_grants [$];

  // Packet sources
  logic [W-1:0] pkt [N][16];
  int  cnt [N];
  int  pos [N];
  bit  auto_src = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs present at that edge
  task automatic model_step();
    int c;
    int lowest;
    bit found;
    if (rst) begin
      m_busy = 0; m_stb = 0; m_exc = 0; m_lock = 0;
      m_g = 0; m_ptr = 0; m_src = 0; m_ack = '0; m_data = '0;
      return;
    end
    if (!m_busy) begin
      m_ack = '0;
      found = 0;
      for (int i = 0; i < int'(N); i++) begin
        c = (m_ptr + i) % N;
        if (!found && bus.in_stb[c] && (!m_lock || c == m_g)) begin
          found  = 1;
          m_g    = c;
          m_ack  = N'(1) << c;
          m_data = bus.in_data[c*W +: W];
          m_stb  = 1;
          m_busy = 1;
        end
      end
    end else begin
      m_ack = '0;
      if (bus.out_ack) begin
        m_busy = 0;
        m_stb  = 0;
        if (LOCK_EN && !m_data[W-1]) begin
          m_lock = 1;
        end else begin
          m_lock = 0;
          m_ptr  = (m_g + 1) % N;
        end
      end
    end
    lowest = -1;
    for (int i = int'(N) - 1; i >= 0; i--) if (bus.exc_in[i]) lowest = i;
    if (lowest >= 0 && (bus.exc_clear || !m_exc)) begin
      m_exc = 1; m_src = lowest;
    end else if (bus.exc_clear) begin
      m_exc = 0; m_src = 0;
    end
  endtask

  task automatic present_sources();
    for (int k = 0; k < int'(N); k++) begin
      if (pos[k] < cnt[k]) begin
        bus.in_stb[k] = 1'b1;
        bus.in_data[k*W +: W] = pkt[k][pos[k]];
      end else begin
        bus.in_stb[k] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("in_ack", W'(bus.in_ack), W'(m_ack));
    check("out_stb", W'(bus.out_stb), W'(m_stb));
    if (m_stb) check("out_data", bus.out_data, m_data);
    check("exception", W'(bus.exception), W'(m_exc));
    check("exc_src", W'(bus.exc_src), W'(m_src));
    for (int k = 0; k < int'(N); k++) if (bus.in_ack[k]) dut_grants.push_back(k);
    if (auto_src) begin
      for (int k = 0; k < int'(N); k++) if (bus.in_ack[k]) pos[k]++;
      present_sources();
    end
  endtask

  task automatic set_word(input int k, input logic [W-1:0] w);
    bus.in_data[k*W +: W] = w;
  endtask

  initial begin
    bus.in_data = '0; bus.in_stb = '0; bus.out_ack = 1'b0;
    bus.exc_in = '0; bus.exc_clear = 1'b0;
    for (int k = 0; k < int'(N); k++) begin cnt[k] = 0; pos[k] = 0; end
    rst = 1'b1;
    tick(); tick();
    check("rst_out_stb", W'(bus.out_stb), '0);
    check("rst_in_ack", W'(bus.in_ack), '0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_exception", W'(bus.exception), '0);
    rst = 1'b0;

    // Single word from channel 2
    set_word(2, 32'h41); bus.in_stb = 4'b0100;
    tick();
    check("t1_ack", W'(bus.in_ack), 32'h4);
    check("t1_data", bus.out_data, 32'h41);
    check("t1_stb", W'(bus.out_stb), 32'h1);
    bus.in_stb = '0;
    tick();
    check("t1_ack_pulse", W'(bus.in_ack), '0);
    bus.out_ack = 1'b1;
    tick();
    check("t1_stb_clr", W'(bus.out_stb), '0);
    bus.out_ack = 1'b0;

    // Fairness with all channels requesting and an always-ready sink
    rst = 1'b1; tick(); rst = 1'b0;
    dut_grants.delete();
    for (int k = 0; k < int'(N); k++) set_word(k, 32'h100 + k);
    bus.in_stb = '1; bus.out_ack = 1'b1;
    repeat (12) tick();
    for (int i = 0; i < 5; i++)
      check("t2_grant", W'((i < dut_grants.size()) ? dut_grants[i] : -1), W'(exp2[i]));

    // Backpressure: word held, no new accept
    bus.out_ack = 1'b0;
    tick();
    check("t3_grant_ack", W'(bus.in_ack), 32'h4);
    repeat (10) begin
      tick();
      check("t3_stb_hold", W'(bus.out_stb), 32'h1);
      check("t3_data_hold", bus.out_data, 32'h102);
      check("t3_no_ack", W'(bus.in_ack), '0);
    end
    bus.out_ack = 1'b1; tick();
    bus.out_ack = 1'b0; bus.in_stb = '0; tick();

    // Sticky exceptions
    bus.exc_in = 4'b1010; tick();
    check("t4_exc", W'(bus.exception), 32'h1);
    check("t4_src1", W'(bus.exc_src), 32'h1);
    bus.exc_in = 4'b1000; tick();
    check("t4_src_frozen", W'(bus.exc_src), 32'h1);
    bus.exc_in = '0; tick();
    bus.exc_clear = 1'b1; bus.exc_in = 4'b0100; tick();
    check("t4_clr_new_exc", W'(bus.exception), 32'h1);
    check("t4_clr_new_src", W'(bus.exc_src), 32'h2);
    bus.exc_in = '0; tick();
    check("t4_cleared", W'(bus.exception), '0);
    bus.exc_clear = 1'b0;

    // Reset while a word is outstanding
    set_word(1, 32'h55); bus.in_stb = 4'b0010; bus.out_ack = 1'b0;
    tick();
    check("t5_stb", W'(bus.out_stb), 32'h1);
    bus.in_stb = '0; rst = 1'b1;
    tick();
    check("t5_rst_stb", W'(bus.out_stb), '0);
    check("t5_rst_ack", W'(bus.in_ack), '0);
    rst = 1'b0; bus.in_stb = '1;
    tick();
    check("t5_ptr_zero", W'(bus.in_ack), 32'h1);
    bus.in_stb = '0; bus.out_ack = 1'b1; tick();
    bus.out_ack = 1'b0; tick();

    // Packet stream on ch0 competing with ch1
    rst = 1'b1; tick(); rst = 1'b0;
    dut_grants.delete();
    pkt[0][0] = 32'h1; pkt[0][1] = 32'h2; pkt[0][2] = 32'h8000_0003; cnt[0] = 3; pos[0] = 0;
    pkt[1][0] = 32'h8000_0011; pkt[1][1] = 32'h8000_0012; cnt[1] = 2; pos[1] = 0;
    cnt[2] = 0; cnt[3] = 0;
    auto_src = 1'b1;
    present_sources();
    bus.out_ack = 1'b1;
    repeat (16) tick();
    for (int i = 0; i < 5; i++)
      check("t6_grant", W'((i < dut_grants.size()) ? dut_grants[i] : -1), W'(exp6[i]));

    // Randomized traffic, sink stalls and exception activity
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < int'(N); k++) begin
        if (pos[k] >= cnt[k] && $urandom_range(0, 5) == 0) begin
          cnt[k] = int'($urandom_range(1, 4));
          pos[k] = 0;
          for (int j = 0; j < cnt[k]; j++) pkt[k][j] = $urandom;
        end
      end
      present_sources();
      bus.out_ack   = ($urandom_range(0, 3) != 0);
      bus.exc_in    = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      bus.exc_clear = ($urandom_range(0, 19) == 0);
      rst           = (cyc == 300);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
